decode_branch_predictor: RTL and testbench
==========================================

Name: decode_branch_predictor

Overview:
- Parametrised successor to the decode-stage branch/jump resolution logic.
- Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters. Fetch queries it combinationally each cycle.
- Decode resolves the actual next PC, detects mispredicts, issues flush and redirect, and trains the table.
- Sits between fetch (lookup port) and decode (resolve port). Also keeps saturating branch and mispredict statistics.

Parameters:
- DATA_W, 16, PC/data width.
- ENTRIES, 16, BTB entries; power of two, at least 2. IDX_W = log2(ENTRIES).
- CTR_W, 2, direction counter width; MSB=1 means predict taken.
- STAT_W, 16, statistics counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- f_pc  in  DATA_W  fetch PC being looked up.
- f_pred_taken  out  1  BTB hit and counter MSB set, or hit on a jump entry.
- f_pred_target  out  DATA_W  stored target on hit, else 0.
- d_valid  in  1  decode slot holds a real instruction.
- d_stall  in  1  decode stalled; no resolve, no training.
- d_branch  in  1  conditional branch.
- d_jump  in  1  unconditional jump (any form).
- d_taken  in  1  branch condition result.
- d_pc  in  DATA_W  decode instruction PC.
- d_pc_inc  in  DATA_W  d_pc+2.
- d_target  in  DATA_W  computed branch/jump target.
- d_pred_next  in  DATA_W  next PC fetch actually used, piped with the instruction.
- flush  out  1  mispredict; squash fetch-stage instruction.
- redirect_pc  out  DATA_W  correct next PC.
- stat_branches  out  STAT_W  resolved branches and jumps.
- stat_mispredicts  out  STAT_W  flushes issued.

Behaviour:
- Index = pc[IDX_W:1], since bit 0 is always 0. Tag = pc[DATA_W-1:IDX_W+1].
- Each entry holds valid, is_jump, tag, target and counter.
- Lookup is purely combinational. Hit = valid & tag match.
- Resolve is active when rst high, d_valid=1 and d_stall=0.
- actual_next = d_target if (d_jump | (d_branch & d_taken)), else d_pc_inc.
- redirect_pc = actual_next. It is driven regardless of resolve state.
- flush = resolve active & (actual_next != d_pred_next). It is combinational and forced 0 while rst low.
- Training happens on the clock edge and only when resolve is active:
  - Taken branch or jump, miss: allocate the entry (valid=1, tag, target, is_jump=d_jump, counter = 10, weakly taken).
  - Taken branch or jump, hit: counter increments (saturating at all-ones); target and is_jump are rewritten.
  - Not-taken branch, hit: counter decrements, saturating at 0. Not-taken branch, miss: no allocation.
  - Non-control instruction that hits (stale or aliased entry): valid is cleared.
- Same-index lookup and update in one cycle: the lookup returns the pre-update contents (read-before-write). There is no bypass.
- Stall held N cycles: no table or stat change; flush=0.
- Statistics:
  - stat_branches increments on resolve-active with (d_branch | d_jump).
  - stat_mispredicts increments on flush.
  - Both saturate at all-ones, with no wrap.
- Reset (rst=0 at a clock edge) applies regardless of other inputs:
  - all valid=0, counters = 01, stats = 0;
  - f_pred_taken=0 and f_pred_target=0 from the next cycle onward.
  - Reset asserted mid-operation discards the pending update.
- d_branch and d_jump both set: treat as jump.

Decomposition:
- Shared package constants: CTR_WEAK_NT=2'b01, CTR_WEAK_T=2'b10, NOP opcode, and index/tag slice helpers as localparams.
- One sub-module, sat_counter (width-parameterised increment/decrement saturating), reused for the direction counters and the statistics counters.
- The BTB array is stored as flops; no SRAM macro.

Test Plan:
1. Reset then lookup: f_pc=0x0040 → f_pred_taken=0, f_pred_target=0; stats 0.
2. Cold taken branch: d_pc=0x0040, d_target=0x0060, d_taken=1, d_pred_next=0x0042 → flush=1, redirect_pc=0x0060, stat_mispredicts=1. Next cycle f_pc=0x0040 → pred_taken=1, target=0x0060.
3. Counter training: same branch resolved taken twice with correct prediction → flush=0, counter 11. Then three not-taken → counter 00, pred_taken=0 with the entry still valid.
4. Stall: d_valid=1, d_stall=1, mispredicting inputs for 3 cycles → flush=0, stats and table unchanged.
5. Aliasing: ENTRIES=16, branch at 0x0040 trained, then a non-control instruction at 0x0060 (same index, different tag) → miss, no flush. If d_pred_next was 0x0060's stale target, flush=1 and the entry is invalidated.
6. Saturation and reset: STAT_W=4, 17 mispredicts → stat_mispredicts=15. Then rst=0 for one edge during a resolve → table cleared, stats 0, no update applied.

Source files
------------

// File: rtl/decode_branch_predictor_pkg.sv
// Shared constants and types for the decode-stage branch predictor.
// Index/tag slicing and direction-counter encodings live here so fetch and decode agree.
package decode_branch_predictor_pkg;

    localparam logic [1:0]  CTR_WEAK_NT = 2'b01;
    localparam logic [1:0]  CTR_WEAK_T  = 2'b10;
    localparam logic [15:0] NOP_OPCODE  = 16'h0000;

    // Instructions are halfword aligned, so the index starts above bit 0.
    localparam int IDX_LSB = 1;

    typedef enum logic [2:0] {
        TRAIN_NONE,
        TRAIN_ALLOC,
        TRAIN_STRENGTHEN,
        TRAIN_WEAKEN,
        TRAIN_INVALIDATE
    } train_e;

endpackage

// File: rtl/decode_branch_predictor_if.sv
// Fetch lookup and decode resolve signals of the branch predictor.
// The master side is fetch/decode, the slave side is the predictor.
interface decode_branch_predictor_if #(
    parameter int DATA_W = 16,
    parameter int STAT_W = 16
);
    logic [DATA_W-1:0] f_pc;
    logic              f_pred_taken;
    logic [DATA_W-1:0] f_pred_target;

    logic              d_valid;
    logic              d_stall;
    logic              d_branch;
    logic              d_jump;
    logic              d_taken;
    logic [DATA_W-1:0] d_pc;
    logic [DATA_W-1:0] d_pc_inc;
    logic [DATA_W-1:0] d_target;
    logic [DATA_W-1:0] d_pred_next;

    logic              flush;
    logic [DATA_W-1:0] redirect_pc;
    logic [STAT_W-1:0] stat_branches;
    logic [STAT_W-1:0] stat_mispredicts;

    modport master (
        output f_pc, d_valid, d_stall, d_branch, d_jump, d_taken,
               d_pc, d_pc_inc, d_target, d_pred_next,
        input  f_pred_taken, f_pred_target, flush, redirect_pc,
               stat_branches, stat_mispredicts
    );

    modport slave (
        input  f_pc, d_valid, d_stall, d_branch, d_jump, d_taken,
               d_pc, d_pc_inc, d_target, d_pred_next,
        output f_pred_taken, f_pred_target, flush, redirect_pc,
               stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/decode_branch_predictor_sat_counter.sv
// Saturating up/down step: returns value+1 / value-1 clamped to [0, all-ones].
// Shared by the BTB direction counters and the statistics counters.
module sat_counter #(
    parameter int W = 2
) (
    input  logic [W-1:0] value,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] result
);
    always_comb begin
        result = value;
        if (inc && !dec && (value != {W{1'b1}})) begin
            result = value + 1'b1;
        end else if (dec && !inc && (value != {W{1'b0}})) begin
            result = value - 1'b1;
        end
    end
endmodule

// File: rtl/decode_branch_predictor.sv
// Direct-mapped BTB with saturating direction counters, decode-stage resolve,
// flush/redirect generation and saturating branch/mispredict statistics.
module decode_branch_predictor
    import decode_branch_predictor_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int STAT_W  = 16
) (
    input logic                      clk,
    input logic                      rst,
    decode_branch_predictor_if.slave bp
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = DATA_W - IDX_W - IDX_LSB;
    localparam int TAG_LSB = IDX_W + IDX_LSB;

    localparam logic [CTR_W-1:0] CTR_RST =
        (CTR_W == 2) ? CTR_W'(CTR_WEAK_NT) : {1'b0, {(CTR_W-1){1'b1}}};
    localparam logic [CTR_W-1:0] CTR_ALLOC =
        (CTR_W == 2) ? CTR_W'(CTR_WEAK_T) : {1'b1, {(CTR_W-1){1'b0}}};

    logic              valid_q   [ENTRIES];
    logic              is_jump_q [ENTRIES];
    logic [TAG_W-1:0]  tag_q     [ENTRIES];
    logic [DATA_W-1:0] target_q  [ENTRIES];
    logic [CTR_W-1:0]  ctr_q     [ENTRIES];

    logic [STAT_W-1:0] stat_branches_q;
    logic [STAT_W-1:0] stat_mispredicts_q;
    logic [STAT_W-1:0] stat_branches_next;
    logic [STAT_W-1:0] stat_mispredicts_next;

    logic [IDX_W-1:0]  f_idx;
    logic [TAG_W-1:0]  f_tag;
    logic              f_hit;

    logic [IDX_W-1:0]  d_idx;
    logic [TAG_W-1:0]  d_tag;
    logic              d_hit;
    logic              resolve;
    logic              is_ctrl;
    logic              taken_ctl;
    logic [DATA_W-1:0] actual_next;
    logic              mispredict;
    train_e            train;
    logic [CTR_W-1:0]  ctr_next;

    logic              unused_pc_lsb;
    assign unused_pc_lsb = ^{bp.f_pc[IDX_LSB-1:0], bp.d_pc[IDX_LSB-1:0]};

    // Fetch lookup reads the array as it stands; same-cycle training lands after.
    assign f_idx = bp.f_pc[IDX_W+IDX_LSB-1:IDX_LSB];
    assign f_tag = bp.f_pc[DATA_W-1:TAG_LSB];
    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

    assign bp.f_pred_taken  = f_hit && (is_jump_q[f_idx] || ctr_q[f_idx][CTR_W-1]);
    assign bp.f_pred_target = f_hit ? target_q[f_idx] : '0;

    assign d_idx = bp.d_pc[IDX_W+IDX_LSB-1:IDX_LSB];
    assign d_tag = bp.d_pc[DATA_W-1:TAG_LSB];
    assign d_hit = valid_q[d_idx] && (tag_q[d_idx] == d_tag);

    assign resolve     = rst && bp.d_valid && !bp.d_stall;
    assign is_ctrl     = bp.d_branch || bp.d_jump;
    assign taken_ctl   = bp.d_jump || (bp.d_branch && bp.d_taken);
    assign actual_next = taken_ctl ? bp.d_target : bp.d_pc_inc;
    assign mispredict  = resolve && (actual_next != bp.d_pred_next);

    assign bp.redirect_pc      = actual_next;
    assign bp.flush            = mispredict;
    assign bp.stat_branches    = stat_branches_q;
    assign bp.stat_mispredicts = stat_mispredicts_q;

    always_comb begin
        train = TRAIN_NONE;
        if (resolve) begin
            if (taken_ctl) begin
                train = d_hit ? TRAIN_STRENGTHEN : TRAIN_ALLOC;
            end else if (bp.d_branch) begin
                train = d_hit ? TRAIN_WEAKEN : TRAIN_NONE;
            end else if (d_hit) begin
                train = TRAIN_INVALIDATE;
            end
        end
    end

    sat_counter #(.W(CTR_W)) u_dir_ctr (
        .value  (ctr_q[d_idx]),
        .inc    (train == TRAIN_STRENGTHEN),
        .dec    (train == TRAIN_WEAKEN),
        .result (ctr_next)
    );

    sat_counter #(.W(STAT_W)) u_stat_branches (
        .value  (stat_branches_q),
        .inc    (resolve && is_ctrl),
        .dec    (1'b0),
        .result (stat_branches_next)
    );

    sat_counter #(.W(STAT_W)) u_stat_mispredicts (
        .value  (stat_mispredicts_q),
        .inc    (mispredict),
        .dec    (1'b0),
        .result (stat_mispredicts_next)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]   <= 1'b0;
                is_jump_q[i] <= 1'b0;
                tag_q[i]     <= '0;
                target_q[i]  <= '0;
                ctr_q[i]     <= CTR_RST;
            end
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            case (train)
                TRAIN_ALLOC: begin
                    valid_q[d_idx]   <= 1'b1;
                    is_jump_q[d_idx] <= bp.d_jump;
                    tag_q[d_idx]     <= d_tag;
                    target_q[d_idx]  <= bp.d_target;
                    ctr_q[d_idx]     <= CTR_ALLOC;
                end
                TRAIN_STRENGTHEN: begin
                    is_jump_q[d_idx] <= bp.d_jump;
                    target_q[d_idx]  <= bp.d_target;
                    ctr_q[d_idx]     <= ctr_next;
                end
                TRAIN_WEAKEN: begin
                    ctr_q[d_idx] <= ctr_next;
                end
                TRAIN_INVALIDATE: begin
                    valid_q[d_idx] <= 1'b0;
                end
                default: ;
            endcase
            stat_branches_q    <= stat_branches_next;
            stat_mispredicts_q <= stat_mispredicts_next;
        end
    end

endmodule

// File: tb/tb_decode_branch_predictor.sv
// Directed bench for decode_branch_predictor: training, stall, aliasing,
// jump handling, statistic saturation and mid-resolve reset.
module tb_decode_branch_predictor;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    decode_branch_predictor_if #(.DATA_W(16), .STAT_W(4)) bp_if ();

    decode_branch_predictor #(
        .DATA_W  (16),
        .ENTRIES (16),
        .CTR_W   (2),
        .STAT_W  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dec(input logic valid, input logic stall, input logic br,
                           input logic jp, input logic tk, input logic [15:0] pc,
                           input logic [15:0] target, input logic [15:0] pred);
        bp_if.d_valid     = valid;
        bp_if.d_stall     = stall;
        bp_if.d_branch    = br;
        bp_if.d_jump      = jp;
        bp_if.d_taken     = tk;
        bp_if.d_pc        = pc;
        bp_if.d_pc_inc    = pc + 16'd2;
        bp_if.d_target    = target;
        bp_if.d_pred_next = pred;
        #1;
    endtask

    task automatic idle();
        set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    endtask

    task automatic look(input string tag, input logic [15:0] pc,
                        input logic exp_taken, input logic [15:0] exp_target);
        bp_if.f_pc = pc;
        #1;
        chk({tag, "_taken"}, 32'(bp_if.f_pred_taken), 32'(exp_taken));
        chk({tag, "_target"}, 32'(bp_if.f_pred_target), 32'(exp_target));
    endtask

    task automatic stats(input string tag, input int exp_b, input int exp_m);
        chk({tag, "_branches"}, 32'(bp_if.stat_branches), 32'(exp_b));
        chk({tag, "_mispredicts"}, 32'(bp_if.stat_mispredicts), 32'(exp_m));
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b0;
        bp_if.f_pc = 16'h0000;
        idle();
        step();
        step();
        rst = 1'b1;

        // 1: reset state
        look("rst_lookup", 16'h0040, 1'b0, 16'h0000);
        stats("rst", 0, 0);

        // 2: cold taken branch, lookup in the same cycle sees pre-update contents
        set_dec(1, 0, 1, 0, 1, 16'h0040, 16'h0060, 16'h0042);
        chk("cold_flush", 32'(bp_if.flush), 32'd1);
        chk("cold_redirect", 32'(bp_if.redirect_pc), 32'h0060);
        look("cold_same_cycle", 16'h0040, 1'b0, 16'h0000);
        step();
        idle();
        look("cold_alloc", 16'h0040, 1'b1, 16'h0060);
        stats("cold", 1, 1);

        // 3: training up to 11, then down to 00
        for (int i = 0; i < 2; i++) begin
            set_dec(1, 0, 1, 0, 1, 16'h0040, 16'h0060, 16'h0060);
            chk("train_t_flush", 32'(bp_if.flush), 32'd0);
            step();
        end
        set_dec(1, 0, 1, 0, 0, 16'h0040, 16'h0060, 16'h0060);
        chk("nt1_flush", 32'(bp_if.flush), 32'd1);
        chk("nt1_redirect", 32'(bp_if.redirect_pc), 32'h0042);
        step();
        look("nt1", 16'h0040, 1'b1, 16'h0060);
        set_dec(1, 0, 1, 0, 0, 16'h0040, 16'h0060, 16'h0060);
        step();
        look("nt2", 16'h0040, 1'b0, 16'h0060);
        set_dec(1, 0, 1, 0, 0, 16'h0040, 16'h0060, 16'h0042);
        chk("nt3_flush", 32'(bp_if.flush), 32'd0);
        step();
        look("nt3", 16'h0040, 1'b0, 16'h0060);
        set_dec(1, 0, 1, 0, 1, 16'h0040, 16'h0060, 16'h0042);
        chk("from00_flush", 32'(bp_if.flush), 32'd1);
        step();
        idle();
        look("from00", 16'h0040, 1'b0, 16'h0060);
        stats("train", 7, 4);

        // 4: stall holds everything
        for (int i = 0; i < 3; i++) begin
            set_dec(1, 1, 1, 0, 1, 16'h0040, 16'h0080, 16'h0042);
            chk("stall_flush", 32'(bp_if.flush), 32'd0);
            step();
        end
        idle();
        look("stall", 16'h0040, 1'b0, 16'h0060);
        stats("stall", 7, 4);

        // 5: aliasing at same index, different tag
        look("alias_miss", 16'h0060, 1'b0, 16'h0000);
        set_dec(1, 0, 0, 0, 0, 16'h0060, 16'h0000, 16'h0062);
        chk("alias_flush", 32'(bp_if.flush), 32'd0);
        step();
        idle();
        look("alias_keep", 16'h0040, 1'b0, 16'h0060);
        set_dec(1, 0, 0, 0, 0, 16'h0040, 16'h0000, 16'h0060);
        chk("stale_flush", 32'(bp_if.flush), 32'd1);
        chk("stale_redirect", 32'(bp_if.redirect_pc), 32'h0042);
        step();
        idle();
        look("stale_inval", 16'h0040, 1'b0, 16'h0000);
        stats("alias", 7, 5);

        // jump allocation, branch+jump treated as jump, not-taken miss
        set_dec(1, 0, 0, 1, 0, 16'h0080, 16'h0100, 16'h0082);
        chk("jump_flush", 32'(bp_if.flush), 32'd1);
        step();
        set_dec(1, 0, 1, 1, 0, 16'h0084, 16'h0200, 16'h0086);
        chk("both_flush", 32'(bp_if.flush), 32'd1);
        chk("both_redirect", 32'(bp_if.redirect_pc), 32'h0200);
        step();
        set_dec(1, 0, 1, 0, 0, 16'h0090, 16'h0300, 16'h0092);
        chk("ntmiss_flush", 32'(bp_if.flush), 32'd0);
        step();
        idle();
        look("jump", 16'h0080, 1'b1, 16'h0100);
        look("both", 16'h0084, 1'b1, 16'h0200);
        look("ntmiss", 16'h0090, 1'b0, 16'h0000);
        stats("jumps", 10, 7);

        // 6: saturation of both statistics
        for (int i = 0; i < 10; i++) begin
            set_dec(1, 0, 0, 1, 0, 16'h0100, 16'h0120, 16'h0102);
            step();
        end
        idle();
        stats("sat", 15, 15);
        look("sat_entry", 16'h0100, 1'b1, 16'h0120);

        // reset during a resolve discards the update
        set_dec(1, 0, 0, 1, 0, 16'h00A0, 16'h0300, 16'h00A2);
        rst = 1'b0;
        #1;
        chk("rst_flush", 32'(bp_if.flush), 32'd0);
        chk("rst_redirect", 32'(bp_if.redirect_pc), 32'h0300);
        step();
        rst = 1'b1;
        idle();
        stats("rst2", 0, 0);
        look("rst2_old", 16'h0100, 1'b0, 16'h0000);
        look("rst2_pending", 16'h00A0, 1'b0, 16'h0000);
        look("rst2_jump", 16'h0084, 1'b0, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
